// File: rtl/pong_pkg.sv
// Shared types, constants and helper functions for the pong frame-rate game sequencer.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4,
        PAUSE = 3'd5
    } game_state_t;

    localparam logic [7:0] SCORE_MAX = 8'd255;
    localparam int         SPEED_W   = 3;

    // Score increment that sticks at the maximum instead of wrapping.
    function automatic logic [7:0] sat_inc_score(input logic [7:0] v);
        logic [7:0] r;
        if (v == SCORE_MAX) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    // Speed increment that saturates at the configured ceiling.
    function automatic logic [SPEED_W-1:0] sat_inc_speed(input logic [SPEED_W-1:0] v,
                                                         input logic [SPEED_W-1:0] vmax);
        logic [SPEED_W-1:0] r;
        if (v >= vmax) begin
            r = v;
        end else begin
            r = v + 3'd1;
        end
        return r;
    endfunction

    // Ball datapath control decoded from a state: {load, run}.
    function automatic logic [1:0] ball_ctrl(input game_state_t s);
        logic [1:0] r;
        case (s)
            IDLE, SERVE, OVER: r = 2'b10;
            PLAY:              r = 2'b01;
            POINT, PAUSE:      r = 2'b00;
            default:           r = 2'b10;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Key/ball inputs and game-control outputs of the pong sequencer.
// master: key/ball side that drives inputs; slave: the sequencer.
interface pong_game_ctrl_if;
    logic       start;
    logic       pause;
    logic [9:0] BallX;
    logic [9:0] BallS;
    logic       paddle_hit;
    logic       ball_load;
    logic       ball_run;
    logic       serve_dir;
    logic [2:0] speed;
    logic [7:0] score;
    logic [1:0] lives;
    logic [2:0] game_state;

    modport master (
        output start, pause, BallX, BallS, paddle_hit,
        input  ball_load, ball_run, serve_dir, speed, score, lives, game_state
    );

    modport slave (
        input  start, pause, BallX, BallS, paddle_hit,
        output ball_load, ball_run, serve_dir, speed, score, lives, game_state
    );
endinterface

// File: rtl/pong_game_ctrl_key_edge_det.sv
// Rising-edge detector for a level key sampled once per frame.
// History resets to 1 so a key held through reset does not fire.
module key_edge_det (
    input  logic frame_clk,
    input  logic Reset_n,
    input  logic key,
    output logic rise
);
    logic key_q_r;

    // Register the key level from the previous frame.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_q_r <= 1'b1;
        end else begin
            key_q_r <= key;
        end
    end

    assign rise = key & ~key_q_r;
endmodule

// File: rtl/pong_game_ctrl.sv
// Pong frame-rate game sequencer: serve countdown, play, miss detection,
// score/speed/lives bookkeeping. One frame_clk cycle is one video frame.
// Optional pause feature is enabled by defining PONG_PAUSE_EN.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SERVE_FRAMES   = 60,
    parameter int LIVES_INIT     = 3,
    parameter int HITS_PER_LEVEL = 5,
    parameter int SPEED_MAX      = 7
) (
    input logic              frame_clk,
    input logic              Reset_n,
    pong_game_ctrl_if.slave  bus
);
    localparam int                    CD_W      = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [CD_W-1:0]       CD_LOAD   = CD_W'(SERVE_FRAMES - 1);
    localparam logic [CD_W-1:0]       CD_ZERO   = CD_W'(0);
    localparam logic [CD_W-1:0]       CD_ONE    = CD_W'(1);
    localparam int                    HC_W      = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
    localparam logic [HC_W-1:0]       HC_LAST   = HC_W'(HITS_PER_LEVEL - 1);
    localparam logic [HC_W-1:0]       HC_ZERO   = HC_W'(0);
    localparam logic [HC_W-1:0]       HC_ONE    = HC_W'(1);
    localparam logic [1:0]            LIVES_RST = 2'(LIVES_INIT);
    localparam logic [SPEED_W-1:0]    SPEED_TOP = SPEED_W'(SPEED_MAX);

    game_state_t        state_r,     state_next_s;
    logic [CD_W-1:0]    countdown_r, countdown_next_s;
    logic [HC_W-1:0]    hit_cnt_r,   hit_cnt_next_s;
    logic [7:0]         score_r,     score_next_s;
    logic [1:0]         lives_r,     lives_next_s;
    logic [SPEED_W-1:0] speed_r,     speed_next_s;
    logic               serve_dir_r, serve_dir_next_s;
    logic               ball_load_r, ball_load_next_s;
    logic               ball_run_r,  ball_run_next_s;
    logic               start_rise_s;
    logic               pause_rise_s;
    logic               miss_s;

    key_edge_det u_start_edge (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .key       (bus.start),
        .rise      (start_rise_s)
    );

`ifdef PONG_PAUSE_EN
    key_edge_det u_pause_edge (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .key       (bus.pause),
        .rise      (pause_rise_s)
    );
`else
    assign pause_rise_s = 1'b0;
`endif

    // Ball has reached the left wall when its left edge is at or past x=0.
    assign miss_s = (bus.BallX <= bus.BallS);

    // Next-state and next-counter logic; ball controls decoded from the next state
    // so they are registered alongside it.
    always_comb begin
        state_next_s     = state_r;
        countdown_next_s = countdown_r;
        hit_cnt_next_s   = hit_cnt_r;
        score_next_s     = score_r;
        lives_next_s     = lives_r;
        speed_next_s     = speed_r;
        serve_dir_next_s = serve_dir_r;

        case (state_r)
            IDLE, OVER: begin
                if (state_r == OVER) begin
                    lives_next_s = 2'd0;
                end else begin
                    lives_next_s = lives_r;
                end
                if (start_rise_s) begin
                    state_next_s     = SERVE;
                    countdown_next_s = CD_LOAD;
                    score_next_s     = 8'd0;
                    lives_next_s     = LIVES_RST;
                    speed_next_s     = 3'd1;
                    hit_cnt_next_s   = HC_ZERO;
                end else begin
                    state_next_s     = state_r;
                end
            end
            SERVE: begin
                if (countdown_r == CD_ZERO) begin
                    state_next_s     = PLAY;
                end else begin
                    countdown_next_s = countdown_r - CD_ONE;
                end
            end
            PLAY: begin
                if (pause_rise_s) begin
                    state_next_s = PAUSE;
                end else begin
                    // A hit in the same frame as a miss still scores.
                    if (bus.paddle_hit) begin
                        score_next_s = sat_inc_score(score_r);
                        if (hit_cnt_r == HC_LAST) begin
                            hit_cnt_next_s = HC_ZERO;
                            speed_next_s   = sat_inc_speed(speed_r, SPEED_TOP);
                        end else begin
                            hit_cnt_next_s = hit_cnt_r + HC_ONE;
                        end
                    end else begin
                        score_next_s = score_r;
                    end
                    if (miss_s) begin
                        state_next_s = POINT;
                    end else begin
                        state_next_s = PLAY;
                    end
                end
            end
            POINT: begin
                lives_next_s     = lives_r - 2'd1;
                serve_dir_next_s = ~serve_dir_r;
                speed_next_s     = 3'd1;
                hit_cnt_next_s   = HC_ZERO;
                if (lives_r == 2'd1) begin
                    state_next_s     = OVER;
                end else begin
                    state_next_s     = SERVE;
                    countdown_next_s = CD_LOAD;
                end
            end
            PAUSE: begin
                if (pause_rise_s) begin
                    state_next_s = PLAY;
                end else begin
                    state_next_s = PAUSE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        {ball_load_next_s, ball_run_next_s} = ball_ctrl(state_next_s);
    end

    // State and game-counter registers.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= IDLE;
            countdown_r <= CD_ZERO;
            hit_cnt_r   <= HC_ZERO;
            score_r     <= 8'd0;
            lives_r     <= LIVES_RST;
            speed_r     <= 3'd1;
            serve_dir_r <= 1'b0;
            ball_load_r <= 1'b1;
            ball_run_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            countdown_r <= countdown_next_s;
            hit_cnt_r   <= hit_cnt_next_s;
            score_r     <= score_next_s;
            lives_r     <= lives_next_s;
            speed_r     <= speed_next_s;
            serve_dir_r <= serve_dir_next_s;
            ball_load_r <= ball_load_next_s;
            ball_run_r  <= ball_run_next_s;
        end
    end

    assign bus.ball_load  = ball_load_r;
    assign bus.ball_run   = ball_run_r;
    assign bus.serve_dir  = serve_dir_r;
    assign bus.speed      = speed_r;
    assign bus.score      = score_r;
    assign bus.lives      = lives_r;
    assign bus.game_state = state_r;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl (SERVE_FRAMES=4, LIVES_INIT=2, HITS_PER_LEVEL=2).
// Works with or without PONG_PAUSE_EN defined.
module tb_pong_game_ctrl;
    import pong_pkg::*;

    typedef struct packed {
        logic [2:0] st;
        logic       ld;
        logic       rn;
        logic       dir;
        logic [2:0] spd;
        logic [7:0] sc;
        logic [1:0] lv;
    } out_t;

    typedef struct packed {
        logic       start;
        logic       pause;
        logic       hit;
        logic [9:0] ballx;
    } stim_t;

    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;
    stim_t stim_q[$];
    out_t  exp_q[$];
    out_t  got;
    out_t  e;

    pong_game_ctrl_if bus ();

    pong_game_ctrl #(
        .SERVE_FRAMES   (4),
        .LIVES_INIT     (2),
        .HITS_PER_LEVEL (2)
    ) dut (
        .frame_clk (clk),
        .Reset_n   (rst_n),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic out_t eo(input game_state_t st, input logic ld, input logic rn,
                                input logic dir, input int spd, input int sc, input int lv);
        out_t o;
        o.st  = st;
        o.ld  = ld;
        o.rn  = rn;
        o.dir = dir;
        o.spd = 3'(spd);
        o.sc  = 8'(sc);
        o.lv  = 2'(lv);
        return o;
    endfunction

    function automatic stim_t sv(input logic start, input logic pause, input logic hit,
                                 input int ballx);
        stim_t s;
        s.start = start;
        s.pause = pause;
        s.hit   = hit;
        s.ballx = 10'(ballx);
        return s;
    endfunction

    function automatic out_t observe();
        return {bus.game_state, bus.ball_load, bus.ball_run, bus.serve_dir,
                bus.speed, bus.score, bus.lives};
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("st=%0d ld=%0b rn=%0b dir=%0b spd=%0d sc=%0d lv=%0d",
                         o.st, o.ld, o.rn, o.dir, o.spd, o.sc, o.lv);
    endfunction

    task automatic push(input stim_t s, input out_t x);
        stim_q.push_back(s);
        exp_q.push_back(x);
    endtask

    // Drive one frame of inputs, then sample just after the next rising edge.
    task automatic apply(input stim_t s);
        bus.start      = s.start;
        bus.pause      = s.pause;
        bus.paddle_hit = s.hit;
        bus.BallX      = s.ballx;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b1; bus.pause = 1'b0; bus.paddle_hit = 1'b0;
        bus.BallX = 10'd300; bus.BallS = 10'd4;
        #12;
        got = observe();
        e = eo(IDLE, 1'b1, 1'b0, 1'b0, 1, 0, 2);
        vec_cnt++;
        if (got !== e) begin
            err_cnt++;
            $display("FAIL reset_values: got %s exp %s", fmt(got), fmt(e));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) push(sv(1, 0, 0, 300), eo(IDLE, 1'b1, 1'b0, 1'b0, 1, 0, 2));
        push(sv(0, 0, 0, 300), eo(IDLE, 1'b1, 1'b0, 1'b0, 1, 0, 2));
        for (int n = 0; stim_q.size() > 0; n++) begin
            apply(stim_q.pop_front());
            got = observe(); e = exp_q.pop_front(); vec_cnt++;
            if (got !== e) begin
                err_cnt++;
                $display("FAIL test_reset step %0d: got %s exp %s", n, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_serve();
        push(sv(1, 0, 0, 300), eo(SERVE, 1'b1, 1'b0, 1'b0, 1, 0, 2));
        for (int i = 0; i < 3; i++) push(sv(0, 0, 0, 300), eo(SERVE, 1'b1, 1'b0, 1'b0, 1, 0, 2));
        push(sv(0, 0, 0, 300), eo(PLAY, 1'b0, 1'b1, 1'b0, 1, 0, 2));
        push(sv(0, 0, 0, 300), eo(PLAY, 1'b0, 1'b1, 1'b0, 1, 0, 2));
        for (int n = 0; stim_q.size() > 0; n++) begin
            apply(stim_q.pop_front());
            got = observe(); e = exp_q.pop_front(); vec_cnt++;
            if (got !== e) begin
                err_cnt++;
                $display("FAIL test_serve step %0d: got %s exp %s", n, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_hits();
        for (int k = 1; k <= 5; k++)
            push(sv(0, 0, 1, 300), eo(PLAY, 1'b0, 1'b1, 1'b0, 1 + k / 2, k, 2));
        push(sv(0, 0, 0, 300), eo(PLAY, 1'b0, 1'b1, 1'b0, 3, 5, 2));
        push(sv(0, 0, 0, 5), eo(PLAY, 1'b0, 1'b1, 1'b0, 3, 5, 2));
        for (int n = 0; stim_q.size() > 0; n++) begin
            apply(stim_q.pop_front());
            got = observe(); e = exp_q.pop_front(); vec_cnt++;
            if (got !== e) begin
                err_cnt++;
                $display("FAIL test_hits step %0d: got %s exp %s", n, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_miss();
        push(sv(0, 0, 0, 4), eo(POINT, 1'b0, 1'b0, 1'b0, 3, 5, 2));
        for (int i = 0; i < 4; i++) push(sv(0, 0, 0, 300), eo(SERVE, 1'b1, 1'b0, 1'b1, 1, 5, 1));
        push(sv(0, 0, 0, 300), eo(PLAY, 1'b0, 1'b1, 1'b1, 1, 5, 1));
        push(sv(1, 0, 0, 300), eo(PLAY, 1'b0, 1'b1, 1'b1, 1, 5, 1));
        push(sv(0, 0, 0, 4), eo(POINT, 1'b0, 1'b0, 1'b1, 1, 5, 1));
        push(sv(0, 0, 0, 300), eo(OVER, 1'b1, 1'b0, 1'b0, 1, 5, 0));
        push(sv(0, 0, 0, 4), eo(OVER, 1'b1, 1'b0, 1'b0, 1, 5, 0));
        push(sv(1, 0, 0, 300), eo(SERVE, 1'b1, 1'b0, 1'b0, 1, 0, 2));
        for (int i = 0; i < 3; i++) push(sv(0, 0, 0, 300), eo(SERVE, 1'b1, 1'b0, 1'b0, 1, 0, 2));
        push(sv(0, 0, 0, 300), eo(PLAY, 1'b0, 1'b1, 1'b0, 1, 0, 2));
        for (int n = 0; stim_q.size() > 0; n++) begin
            apply(stim_q.pop_front());
            got = observe(); e = exp_q.pop_front(); vec_cnt++;
            if (got !== e) begin
                err_cnt++;
                $display("FAIL test_miss step %0d: got %s exp %s", n, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_hit_miss();
        push(sv(0, 0, 1, 4), eo(POINT, 1'b0, 1'b0, 1'b0, 1, 1, 2));
        for (int i = 0; i < 4; i++) push(sv(0, 0, 0, 300), eo(SERVE, 1'b1, 1'b0, 1'b1, 1, 1, 1));
        push(sv(0, 0, 0, 300), eo(PLAY, 1'b0, 1'b1, 1'b1, 1, 1, 1));
        push(sv(0, 0, 1, 300), eo(PLAY, 1'b0, 1'b1, 1'b1, 1, 2, 1));
        for (int n = 0; stim_q.size() > 0; n++) begin
            apply(stim_q.pop_front());
            got = observe(); e = exp_q.pop_front(); vec_cnt++;
            if (got !== e) begin
                err_cnt++;
                $display("FAIL test_hit_miss step %0d: got %s exp %s", n, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.paddle_hit = 1'b0;
        rst_n = 1'b0;
        #2;
        got = observe();
        e = eo(IDLE, 1'b1, 1'b0, 1'b0, 1, 0, 2);
        vec_cnt++;
        if (got !== e) begin
            err_cnt++;
            $display("FAIL reset_mid: got %s exp %s", fmt(got), fmt(e));
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(sv(0, 0, 1, 4), eo(IDLE, 1'b1, 1'b0, 1'b0, 1, 0, 2));
        push(sv(0, 0, 0, 300), eo(IDLE, 1'b1, 1'b0, 1'b0, 1, 0, 2));
        for (int n = 0; stim_q.size() > 0; n++) begin
            apply(stim_q.pop_front());
            got = observe(); e = exp_q.pop_front(); vec_cnt++;
            if (got !== e) begin
                err_cnt++;
                $display("FAIL test_reset_mid step %0d: got %s exp %s", n, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_pause();
        push(sv(0, 1, 0, 300), eo(IDLE, 1'b1, 1'b0, 1'b0, 1, 0, 2));
        push(sv(1, 0, 0, 300), eo(SERVE, 1'b1, 1'b0, 1'b0, 1, 0, 2));
        for (int i = 0; i < 3; i++) push(sv(0, 0, 0, 300), eo(SERVE, 1'b1, 1'b0, 1'b0, 1, 0, 2));
        push(sv(0, 0, 0, 300), eo(PLAY, 1'b0, 1'b1, 1'b0, 1, 0, 2));
`ifdef PONG_PAUSE_EN
        push(sv(0, 1, 0, 300), eo(PAUSE, 1'b0, 1'b0, 1'b0, 1, 0, 2));
        push(sv(0, 1, 1, 300), eo(PAUSE, 1'b0, 1'b0, 1'b0, 1, 0, 2));
        push(sv(0, 0, 1, 4),   eo(PAUSE, 1'b0, 1'b0, 1'b0, 1, 0, 2));
        push(sv(0, 1, 0, 300), eo(PLAY,  1'b0, 1'b1, 1'b0, 1, 0, 2));
        push(sv(0, 0, 1, 300), eo(PLAY,  1'b0, 1'b1, 1'b0, 1, 1, 2));
`else
        push(sv(0, 1, 0, 300), eo(PLAY, 1'b0, 1'b1, 1'b0, 1, 0, 2));
        push(sv(0, 1, 1, 300), eo(PLAY, 1'b0, 1'b1, 1'b0, 1, 1, 2));
        push(sv(0, 0, 1, 300), eo(PLAY, 1'b0, 1'b1, 1'b0, 2, 2, 2));
        push(sv(0, 1, 0, 300), eo(PLAY, 1'b0, 1'b1, 1'b0, 2, 2, 2));
        push(sv(0, 0, 1, 300), eo(PLAY, 1'b0, 1'b1, 1'b0, 2, 3, 2));
`endif
        for (int n = 0; stim_q.size() > 0; n++) begin
            apply(stim_q.pop_front());
            got = observe(); e = exp_q.pop_front(); vec_cnt++;
            if (got !== e) begin
                err_cnt++;
                $display("FAIL test_pause step %0d: got %s exp %s", n, fmt(got), fmt(e));
            end
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n = 1'b0;
        test_reset();
        test_serve();
        test_hits();
        test_miss();
        test_hit_miss();
        test_reset_mid();
        test_pause();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
